// File: rtl/alu_div32_seq.sv
// rtl/alu_div32_seq.sv - multi-cycle radix-2 restoring divider with ALU-style status flags
module alu_div32_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             zero,
  output logic             N,
  output logic             overflow,
  output logic             carryout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int               CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONES    = {WIDTH{1'b1}};

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] a_raw;
  logic [WIDTH-1:0] b_raw;
  logic             sgn;
  logic             neg_q;
  logic             neg_r;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   r_diff;
  logic             r_ge;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic             ovf_fix;

  always_comb begin
    a_neg = signed_op & in0[WIDTH-1];
    b_neg = signed_op & in1[WIDTH-1];
    a_abs = a_neg ? -in0 : in0;
    b_abs = b_neg ? -in1 : in1;
  end

  // One restoring step: shift the next dividend bit into the partial remainder.
  always_comb begin
    r_sh   = {r[WIDTH-1:0], q[WIDTH-1]};
    r_diff = r_sh - {1'b0, d};
    r_ge   = (r_sh >= {1'b0, d});
  end

  always_comb begin
    q_fix   = neg_q ? -q : q;
    r_fix   = neg_r ? -r[WIDTH-1:0] : r[WIDTH-1:0];
    ovf_fix = 1'b0;
    if (b_raw == '0) begin
      q_fix   = ONES;
      r_fix   = a_raw;
      ovf_fix = 1'b1;
    end else if (sgn && (a_raw == MIN_VAL) && (b_raw == ONES)) begin
      q_fix   = MIN_VAL;
      r_fix   = '0;
      ovf_fix = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      r        <= '0;
      q        <= '0;
      d        <= '0;
      a_raw    <= '0;
      b_raw    <= '0;
      sgn      <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      quot     <= '0;
      rem      <= '0;
      zero     <= 1'b0;
      N        <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_raw <= in0;
            b_raw <= in1;
            sgn   <= signed_op;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            r     <= '0;
            q     <= a_abs;
            d     <= b_abs;
            cnt   <= '0;
            state <= S_CALC;
          end
        end
        S_CALC: begin
          // Divide-by-zero runs the full loop too, keeping latency constant.
          r   <= r_ge ? r_diff : r_sh;
          q   <= {q[WIDTH-2:0], r_ge};
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          quot     <= q_fix;
          rem      <= r_fix;
          zero     <= (q_fix == '0);
          N        <= q_fix[WIDTH-1];
          overflow <= ovf_fix;
          state    <= S_DONE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = (state == S_CALC) || (state == S_FIX);
  assign done     = (state == S_DONE);
  assign carryout = 1'b0;

endmodule
